subbytes_arbiter: RTL and testbench
===================================

SUBBYTES_ARBITER -- requirements
Module: subbytes_arbiter

Interface
REQ-001 Parameter ROUND_ROBIN, default 1, arbitration mode: 1 = round-robin, 0 = fixed priority with requester 0 highest.
REQ-002 i_clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 i_reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_hold  input  1  when high, blocks new grants; in-flight results still complete.
REQ-005 i_req0_valid  input  1  requester 0 (cipher datapath) has a 128-bit state to substitute.
REQ-006 i_req0_data  input  128  requester 0 state, bit 0 = MSB of byte 0.
REQ-007 o_req0_ready  output  1  requester 0 granted this cycle.
REQ-008 i_req1_valid  input  1  requester 1 (key schedule) has a word to substitute.
REQ-009 i_req1_data  input  128  requester 1 data, same byte order as requester 0.
REQ-010 o_req1_ready  output  1  requester 1 granted this cycle.
REQ-011 o_rsp0_valid  output  1  o_rsp_data holds the result for requester 0, one-cycle pulse.
REQ-012 o_rsp1_valid  output  1  o_rsp_data holds the result for requester 1, one-cycle pulse.
REQ-013 o_rsp_data  output  128  shared result bus; its value is meaningful only while o_rsp0_valid or o_rsp1_valid is high.
REQ-014 o_last_grant  output  1  index of the most recently granted requester.

Function
REQ-015 The block shall instantiate exactly one SubBytes block: 128-bit, registered, one-cycle latency, updates only while its enable is high, no reset.
REQ-016 Handshake: a transfer occurs on a cycle where valid and ready are both high; the requester may drop valid or change data after that cycle.
REQ-017 At most one of o_req0_ready and o_req1_ready shall be high in any cycle.
REQ-018 o_reqN_ready shall be combinational from i_reqN_valid, i_req(1-N)_valid, i_hold and the priority pointer, and shall never be high while its own valid is low.
REQ-019 With i_hold high, both readies shall be 0.
REQ-020 Single valid requester, i_hold low: that requester is granted the same cycle.
REQ-021 Both valid, ROUND_ROBIN=1: the requester not equal to o_last_grant is granted.
REQ-022 Both valid, ROUND_ROBIN=0: requester 0 is always granted.
REQ-023 On a grant, the SubBytes enable shall be driven high and its input muxed to the granted data in that same cycle; on all other cycles the enable is low.
REQ-024 o_last_grant shall update on the clock edge ending a grant cycle and hold otherwise.
REQ-025 Latency: a grant in cycle N shall raise o_rspN_valid for exactly cycle N+1, with o_rsp_data = byte-wise S-box of the granted data.
REQ-026 Throughput: one grant per cycle; back-to-back grants yield back-to-back responses, each tagged to its own requester.
REQ-027 o_rsp0_valid and o_rsp1_valid shall never be high in the same cycle.
REQ-028 Responses have no backpressure; requesters shall capture the result in the valid cycle.
REQ-029 With no grant, o_rsp_data shall hold the last result, since SubBytes is not enabled.
REQ-030 The grant decision shall not depend on response state; a grant is allowed in the same cycle a response is presented.

Reset
REQ-031 While i_reset_n is low: readies, o_rsp0_valid and o_rsp1_valid shall be 0, and o_last_grant shall be 1 so that requester 0 wins the first contention.
REQ-032 Reset asserted mid-operation shall discard any in-flight response; no rspN_valid pulse may appear after reset for a pre-reset grant.
REQ-033 o_rsp_data is unspecified after reset until the first response.
REQ-034 Reset release is synchronised internally so that the first grant is possible on the second rising edge after deassertion.

Verification
REQ-035 Request 0 only with data 000102030405060708090a0b0c0d0e0f -> o_req0_ready same cycle; next cycle o_rsp0_valid=1, o_rsp_data=637c777bf26b6fc53001672bfed7ab76.
REQ-036 Both valid for 4 cycles, ROUND_ROBIN=1, after reset, req0 data all 00 and req1 data all ff -> grants 0,1,0,1; responses alternate rsp0 with 6363..63 and rsp1 with 1616..16.
REQ-037 Same stimulus with ROUND_ROBIN=0 -> four req0 grants, no req1 grant, o_last_grant=0.
REQ-038 Grant req1 with data all 53, then raise i_hold in the next cycle -> o_rsp1_valid=1 with data all ed in that cycle, no new grant while i_hold=1, o_rsp_data holds all ed.
REQ-039 Grant req0, then assert i_reset_n low before the next edge -> no o_rsp0_valid pulse, all outputs 0 and o_last_grant=1.
REQ-040 Random valid/hold traffic for 10k cycles -> grants never overlap, every grant gets exactly one tagged response one cycle later matching the S-box model, and neither requester waits more than 1 cycle under round-robin contention.

Source files
------------

// File: rtl/subbytes_arbiter.sv
// -----------------------------------------------------------------------------
// subbytes_arbiter
//   Shares a single 128-bit AES SubBytes stage between two requesters: the
//   cipher datapath (requester 0) and the key schedule (requester 1).
//   A grant is issued combinationally in the cycle the request is seen.
//   The tagged result appears one cycle later on a shared response bus.
//
// Parameters
//   ROUND_ROBIN   1 = alternate under contention, 0 = requester 0 always wins
//
// Ports
//   i_clock        clock, all state on rising edge
//   i_reset_n      asynchronous active-low reset
//   i_hold         blocks new grants (in-flight result still completes)
//   i_req0_valid   requester 0 request
//   i_req0_data    requester 0 128-bit state
//   o_req0_ready   requester 0 granted this cycle
//   i_req1_valid   requester 1 request
//   i_req1_data    requester 1 128-bit data
//   o_req1_ready   requester 1 granted this cycle
//   o_rsp0_valid   o_rsp_data is requester 0's result (one-cycle pulse)
//   o_rsp1_valid   o_rsp_data is requester 1's result (one-cycle pulse)
//   o_rsp_data     shared result bus, holds last result when idle
//   o_last_grant   index of the most recently granted requester
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// subbytes_core
//   Registered 128-bit SubBytes, one-cycle latency, captures only while en is
//   high, no reset. The S-box is computed arithmetically: multiplicative
//   inverse in GF(2^8) (x^254) followed by the AES affine transform.
//
// Ports
//   clk   clock
//   en    capture enable
//   d     input state
//   q     substituted state (registered)
// -----------------------------------------------------------------------------
module subbytes_core (
    input  logic         clk,
    input  logic         en,
    input  logic [127:0] d,
    output logic [127:0] q
);
    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Inverse as x^254; maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] pw;
        logic [7:0] e;
        r  = 8'h01;
        pw = x;
        e  = 8'hfe;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, pw);
            pw = gf_mul(pw, pw);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    logic [127:0] sub_next;
    logic [127:0] sub_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            assign sub_next[gi*8 +: 8] = sbox(d[gi*8 +: 8]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (en) sub_reg <= sub_next;
    end

    assign q = sub_reg;
endmodule

module subbytes_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic         i_clock,
    input  logic         i_reset_n,
    input  logic         i_hold,
    input  logic         i_req0_valid,
    input  logic [127:0] i_req0_data,
    output logic         o_req0_ready,
    input  logic         i_req1_valid,
    input  logic [127:0] i_req1_data,
    output logic         o_req1_ready,
    output logic         o_rsp0_valid,
    output logic         o_rsp1_valid,
    output logic [127:0] o_rsp_data,
    output logic         o_last_grant
);
    logic         run_reg;        // grants enabled once reset release is seen on a clock edge
    logic         last_grant_reg;
    logic         rsp0_reg;
    logic         rsp1_reg;
    logic         grant0;
    logic         grant1;
    logic         sb_en;
    logic [127:0] sb_in;

    // Reset is released synchronously: the first edge after deassertion sets
    // run_reg, so the earliest transfer completes on the second edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            run_reg        <= 1'b0;
            last_grant_reg <= 1'b1;   // requester 0 wins the first contention
            rsp0_reg       <= 1'b0;
            rsp1_reg       <= 1'b0;
        end else begin
            run_reg  <= 1'b1;
            rsp0_reg <= grant0;
            rsp1_reg <= grant1;
            if (grant0)
                last_grant_reg <= 1'b0;
            else if (grant1)
                last_grant_reg <= 1'b1;
        end
    end

    // Grant depends only on valids, hold and the pointer; response state is
    // deliberately ignored so a new grant can overlap a presented response.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (run_reg && !i_hold) begin
            if (i_req0_valid && i_req1_valid) begin
                if ((ROUND_ROBIN != 0) && (last_grant_reg == 1'b0))
                    grant1 = 1'b1;
                else
                    grant0 = 1'b1;
            end else begin
                grant0 = i_req0_valid;
                grant1 = i_req1_valid;
            end
        end
    end

    assign sb_en = grant0 | grant1;
    assign sb_in = grant1 ? i_req1_data : i_req0_data;

    subbytes_core u_subbytes (
        .clk (i_clock),
        .en  (sb_en),
        .d   (sb_in),
        .q   (o_rsp_data)
    );

    assign o_req0_ready = grant0;
    assign o_req1_ready = grant1;
    assign o_rsp0_valid = rsp0_reg;
    assign o_rsp1_valid = rsp1_reg;
    assign o_last_grant = last_grant_reg;
endmodule

// File: tb/tb_subbytes_arbiter.sv
// -----------------------------------------------------------------------------
// tb_subbytes_arbiter
//   Runs a round-robin instance and a fixed-priority instance side by side on
//   shared stimulus. A per-cycle model checks both. Directed scenarios pin the
//   model with hand-computed values, then random valid/hold traffic follows.
// -----------------------------------------------------------------------------
module tb_subbytes_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hold = 1'b0;
    logic         v0 = 1'b0;
    logic         v1 = 1'b0;
    logic [127:0] d0 = '0;
    logic [127:0] d1 = '0;

    // index 1 = round-robin instance, index 0 = fixed-priority instance
    logic [1:0]   r0, r1, rv0, rv1, lg;
    logic [127:0] rd_rr, rd_fp;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    subbytes_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .i_clock(clk), .i_reset_n(rst_n), .i_hold(hold),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0[1]),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1[1]),
        .o_rsp0_valid(rv0[1]), .o_rsp1_valid(rv1[1]),
        .o_rsp_data(rd_rr), .o_last_grant(lg[1])
    );

    subbytes_arbiter #(.ROUND_ROBIN(0)) u_fp (
        .i_clock(clk), .i_reset_n(rst_n), .i_hold(hold),
        .i_req0_valid(v0), .i_req0_data(d0), .o_req0_ready(r0[0]),
        .i_req1_valid(v1), .i_req1_data(d1), .o_req1_ready(r1[0]),
        .o_rsp0_valid(rv0[0]), .o_rsp1_valid(rv1[0]),
        .o_rsp_data(rd_fp), .o_last_grant(lg[0])
    );

    // Standard AES S-box, row-major
    logic [7:0]    sbox_tab [256];
    logic [2047:0] sbox_flat;
    initial begin
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_tab[i] = sbox_flat[2047 - 8*i -: 8];
    end

    function automatic logic [127:0] sub_model(input logic [127:0] x);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_tab[x[8*k +: 8]];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ------------------------------------------------------------------
    // Per-cycle model and compare, sampled on the falling edge
    // ------------------------------------------------------------------
    logic         m_last [2]       = '{1'b1, 1'b1};
    logic         m_pend0 [2]      = '{1'b0, 1'b0};
    logic         m_pend1 [2]      = '{1'b0, 1'b0};
    logic         m_shown_ok [2]   = '{1'b0, 1'b0};
    logic [127:0] m_shown [2];
    logic         m_armed = 1'b0;
    int           wait0 = 0;
    int           wait1 = 0;

    always @(negedge clk) begin
        logic         g0, g1;
        logic [127:0] act_data;
        string        tg;
        for (int m = 0; m < 2; m++) begin
            tg = (m == 1) ? "rr" : "fp";
            act_data = (m == 1) ? rd_rr : rd_fp;
            if (!rst_n) begin
                check({"rst_ready0_", tg}, r0[m], 1'b0);
                check({"rst_ready1_", tg}, r1[m], 1'b0);
                check({"rst_rsp0_", tg}, rv0[m], 1'b0);
                check({"rst_rsp1_", tg}, rv1[m], 1'b0);
                check({"rst_last_", tg}, lg[m], 1'b1);
                m_last[m] = 1'b1;
                m_pend0[m] = 1'b0;
                m_pend1[m] = 1'b0;
                m_shown_ok[m] = 1'b0;
            end else begin
                g0 = 1'b0;
                g1 = 1'b0;
                if (m_armed && !hold) begin
                    if (v0 && v1) begin
                        if (m == 1) begin
                            g0 = (m_last[m] == 1'b1);
                            g1 = (m_last[m] == 1'b0);
                        end else begin
                            g0 = 1'b1;
                        end
                    end else begin
                        g0 = v0;
                        g1 = v1;
                    end
                end
                check({"ready0_", tg}, r0[m], g0);
                check({"ready1_", tg}, r1[m], g1);
                check({"rsp0_valid_", tg}, rv0[m], m_pend0[m]);
                check({"rsp1_valid_", tg}, rv1[m], m_pend1[m]);
                check({"last_grant_", tg}, lg[m], m_last[m]);
                if (m_shown_ok[m]) check({"rsp_data_", tg}, act_data, m_shown[m]);
                m_pend0[m] = g0;
                m_pend1[m] = g1;
                if (g0 || g1) begin
                    m_shown[m] = sub_model(g1 ? d1 : d0);
                    m_shown_ok[m] = 1'b1;
                    m_last[m] = g1;
                end
            end
        end
        if (!rst_n) begin
            m_armed = 1'b0;
            wait0 = 0;
            wait1 = 0;
        end else begin
            // round-robin bound: an eligible requester is never passed over twice running
            if (m_armed && !hold && v0 && !r0[1]) begin
                wait0++;
                check("rr_wait0", (wait0 <= 1), 1'b1);
            end else wait0 = 0;
            if (m_armed && !hold && v1 && !r1[1]) begin
                wait1++;
                check("rr_wait1", (wait1 <= 1), 1'b1);
            end else wait1 = 0;
            m_armed = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus with hand-computed literal expectations
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with both requesting: nothing may be granted
        rst_n = 1'b0; hold = 1'b0; v0 = 1'b1; v1 = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("lit_rst_ready0", r0[1], 1'b0);
        check("lit_rst_last", lg[1], 1'b1);
        step();
        v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
        step();
        step();

        // single requester 0, known vector
        v0 = 1'b1; d0 = 128'h000102030405060708090a0b0c0d0e0f;
        @(negedge clk);
        check("lit35_ready0", r0[1], 1'b1);
        check("lit35_ready1", r1[1], 1'b0);
        step();
        v0 = 1'b0;
        @(negedge clk);
        check("lit35_rsp0", rv0[1], 1'b1);
        check("lit35_data", rd_rr, 128'h637c777bf26b6fc53001672bfed7ab76);
        step();

        // fresh reset, then 4 cycles of contention
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        v0 = 1'b1; v1 = 1'b1; d0 = '0; d1 = '1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("lit36_ready0_rr", r0[1], (k % 2 == 0));
            check("lit36_ready1_rr", r1[1], (k % 2 == 1));
            check("lit37_ready0_fp", r0[0], 1'b1);
            check("lit37_ready1_fp", r1[0], 1'b0);
            if (k > 0) begin
                check("lit36_rsp0_rr", rv0[1], ((k - 1) % 2 == 0));
                check("lit36_data_rr", rd_rr, ((k - 1) % 2 == 0) ? {16{8'h63}} : {16{8'h16}});
                check("lit37_data_fp", rd_fp, {16{8'h63}});
            end
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        @(negedge clk);
        check("lit36_rsp1_rr", rv1[1], 1'b1);
        check("lit36_last_data", rd_rr, {16{8'h16}});
        check("lit37_last_fp", lg[0], 1'b0);
        check("lit37_rsp1_fp", rv1[0], 1'b0);
        step();

        // grant req1, then hold with both requesting
        v1 = 1'b1; d1 = {16{8'h53}};
        @(negedge clk);
        check("lit38_ready1", r1[1], 1'b1);
        step();
        hold = 1'b1; v0 = 1'b1;
        @(negedge clk);
        check("lit38_rsp1", rv1[1], 1'b1);
        check("lit38_data", rd_rr, {16{8'hed}});
        check("lit38_hold_ready0", r0[1], 1'b0);
        check("lit38_hold_ready1", r1[1], 1'b0);
        step();
        @(negedge clk);
        check("lit38_rsp1_gone", rv1[1], 1'b0);
        check("lit38_data_held", rd_rr, {16{8'hed}});
        step();
        hold = 1'b0; v1 = 1'b0;

        // grant req0, then reset before the edge that would launch the response
        @(negedge clk);
        check("lit39_ready0", r0[1], 1'b1);
        #1 rst_n = 1'b0;
        step();
        v0 = 1'b0;
        @(negedge clk);
        check("lit39_rsp0", rv0[1], 1'b0);
        check("lit39_ready0_rst", r0[1], 1'b0);
        check("lit39_last", lg[1], 1'b1);
        step();
        rst_n = 1'b1;
        repeat (4) step();

        // random valid/hold traffic
        for (int c = 0; c < 10000; c++) begin
            v0   = ($urandom_range(0, 99) < 70);
            v1   = ($urandom_range(0, 99) < 70);
            hold = ($urandom_range(0, 99) < 15);
            d0   = {$urandom, $urandom, $urandom, $urandom};
            d1   = {$urandom, $urandom, $urandom, $urandom};
            step();
        end
        v0 = 1'b0; v1 = 1'b0; hold = 1'b0;
        step();
        step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
